// File: rtl/mem_init_port.sv
// mem_init_port: SRAM front end that fills every word with INIT_VALUE
// after reset or on request, then opens a single-port client path.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   init_req              one-cycle request to refill the SRAM (RUN only)
//   init_done             high while client access is open
//   req_valid/req_ready   client request handshake
//   req_wmode/addr/wdata/wmask  client request fields (1 = write)
//   rsp_valid/rsp_rdata   read response, one cycle after acceptance
//   mem_en/we/addr/din    SRAM control and write data
//   mem_dout              SRAM read data, one cycle after an enabled read
module mem_init_port #(
   parameter int                         MEM_DATAWIDTH = 64,
   parameter int                         MEM_ADDRWIDTH = 14,
   parameter logic [MEM_DATAWIDTH-1:0]   INIT_VALUE    = '0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          init_req,
   output logic                          init_done,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_wmode,
   input  logic [MEM_ADDRWIDTH-1:0]      req_addr,
   input  logic [MEM_DATAWIDTH-1:0]      req_wdata,
   input  logic [MEM_DATAWIDTH/8-1:0]    req_wmask,
   output logic                          rsp_valid,
   output logic [MEM_DATAWIDTH-1:0]      rsp_rdata,
   output logic                          mem_en,
   output logic [MEM_DATAWIDTH/8-1:0]    mem_we,
   output logic [MEM_ADDRWIDTH-1:0]      mem_addr,
   output logic [MEM_DATAWIDTH-1:0]      mem_din,
   input  logic [MEM_DATAWIDTH-1:0]      mem_dout
);

   localparam int NB = MEM_DATAWIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_RUN
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [MEM_ADDRWIDTH-1:0] r_cnt;
   logic [MEM_ADDRWIDTH-1:0] w_cnt_next;
   logic                   r_init_done;
   logic                   r_rsp_valid;
   logic                   w_cnt_last;
   logic                   w_accept;
   logic                   w_rd_accept;

   assign w_cnt_last  = &r_cnt;
   // init_req closes the door on the same cycle's request
   assign w_accept    = (r_state == S_RUN) & req_valid & ~init_req;
   assign w_rd_accept = w_accept & ~req_wmode;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      mem_en     = 1'b0;
      mem_we     = '0;
      mem_addr   = '0;
      mem_din    = '0;
      req_ready  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_next     = S_INIT;
            w_cnt_next = '0;
         end
         S_INIT: begin
            mem_en   = 1'b1;
            mem_we   = '1;
            mem_addr = r_cnt;
            mem_din  = INIT_VALUE;
            // last word: leave on this edge instead of wrapping
            if (w_cnt_last) begin
               w_next     = S_RUN;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            req_ready = ~init_req;
            mem_en    = w_accept;
            mem_we    = {NB{w_accept & req_wmode}} & req_wmask;
            mem_addr  = req_addr;
            mem_din   = req_wdata;
            if (init_req) begin
               w_next     = S_INIT;
               w_cnt_next = '0;
            end
         end
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         r_init_done <= (w_next == S_RUN);
         r_rsp_valid <= w_rd_accept;
      end
   end

   assign init_done = r_init_done;
   assign rsp_valid = r_rsp_valid;
   // SRAM data is only exposed alongside its valid
   assign rsp_rdata = r_rsp_valid ? mem_dout : '0;

endmodule
